// File: rtl/simon_pkg.sv
// Shared types, constants and helpers for the Simon game controller.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_GAP,
    S_WAIT_IN,
    S_WIN,
    S_LOSE
  } state_t;

  typedef logic [1:0] sym_t;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Map a 2-bit symbol onto the LED it lights.
  function automatic logic [3:0] onehot(input sym_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit right-shifting Galois LFSR; advances on every clock, free-running.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next state: shift right, fold the taps in when a one falls out.
  always_comb begin
    q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_TAPS) : (q_q >> 1);
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/simon_ctrl.sv
// Simon memory-game controller: grows a random pattern one symbol per round,
// replays it on the LEDs, then checks the player's one-hot entries.
// Optional build macro SIMON_TIMEOUT_EN: lose after TIMEOUT_CYCLES idle
// cycles while waiting for player input.
module simon_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEVEL      = 16,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [3:0]                     in_sw,
  output logic [3:0]                     led,
  output logic                           listen,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level,
  output logic                           win,
  output logic                           lose
);

  localparam int LVL_W     = $clog2(MAX_LEVEL + 1);
  localparam int PAT_DEPTH = 2 ** LVL_W;
  localparam int CNT_MAX   = (SHOW_CYCLES >= GAP_CYCLES) ?
                             ((SHOW_CYCLES >= TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES) :
                             ((GAP_CYCLES  >= TIMEOUT_CYCLES) ? GAP_CYCLES  : TIMEOUT_CYCLES);
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(MAX_LEVEL);

  state_t            state_q,  state_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  logic [LVL_W-1:0]  idx_q,    idx_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [3:0]        led_q,    led_d;
  logic              listen_q, listen_d;
  logic              win_q,    win_d;
  logic              lose_q,   lose_d;

  sym_t              pattern_q [PAT_DEPTH];
  logic              pat_we;

  logic [15:0]       lfsr_q;
  logic              unused_lfsr;
  logic [LVL_W-1:0]  next_idx;
  logic              last_step;
  sym_t              first_sym;

  simon_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Only the two low LFSR bits feed the pattern.
  assign unused_lfsr = ^lfsr_q[15:2];
  assign next_idx    = idx_q + LVL_W'(1);
  assign last_step   = (idx_q == level_q - LVL_W'(1));
  // In ADD of round one, pattern[0] is written on the same edge that SHOW_ON starts.
  assign first_sym   = (level_q == '0) ? lfsr_q[1:0] : pattern_q[0];

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    listen_d = listen_q;
    win_d    = win_q;
    lose_d   = lose_q;
    pat_we   = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_ADD;
          level_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
          led_d   = 4'b0000;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end
      end
      S_ADD: begin
        pat_we  = 1'b1;
        level_d = level_q + LVL_W'(1);
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SHOW_ON;
        led_d   = onehot(first_sym);
      end
      S_SHOW_ON: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = S_SHOW_GAP;
          cnt_d   = '0;
          led_d   = 4'b0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHOW_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (last_step) begin
            state_d  = S_WAIT_IN;
            idx_d    = '0;
            listen_d = 1'b1;
          end else begin
            state_d = S_SHOW_ON;
            idx_d   = next_idx;
            led_d   = onehot(pattern_q[next_idx]);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          cnt_d = '0;
          if (in_sw == onehot(pattern_q[idx_q])) begin
            if (last_step) begin
              listen_d = 1'b0;
              if (level_q == LVL_MAX) begin
                state_d = S_WIN;
                win_d   = 1'b1;
                led_d   = 4'b1111;
              end else begin
                state_d = S_ADD;
              end
            end else begin
              idx_d = next_idx;
            end
          end else begin
            state_d  = S_LOSE;
            lose_d   = 1'b1;
            listen_d = 1'b0;
            led_d    = 4'b0000;
          end
        end else begin
`ifdef SIMON_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            state_d  = S_LOSE;
            cnt_d    = '0;
            lose_d   = 1'b1;
            listen_d = 1'b0;
            led_d    = 4'b0000;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      led_q    <= 4'b0000;
      listen_q <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      listen_q <= listen_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  // Pattern memory; entries at or above level are never read, so no reset.
  always_ff @(posedge clk) begin
    if (pat_we) pattern_q[level_q] <= lfsr_q[1:0];
  end

  assign led    = led_q;
  assign listen = listen_q;
  assign level  = level_q;
  assign win    = win_q;
  assign lose   = lose_q;

endmodule

// File: tb/tb_simon_ctrl.sv
// Self-checking bench for simon_ctrl with randomized entries and noise.
// Build with SIMON_TIMEOUT_EN defined to exercise the input timeout.
module tb_simon_ctrl;

  localparam int ML = 3;
  localparam int SC = 3;
  localparam int GC = 2;
  localparam int TC = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [3:0] in_sw;
  logic [3:0] led;
  logic       listen;
  logic [1:0] level;
  logic       win;
  logic       lose;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: free-running LFSR per the published seed/taps, and the
  // expected pattern as a list of symbols.
  logic [15:0] m_lfsr;
  int          pat[$];

  always #5 clk = ~clk;

  simon_ctrl #(
    .MAX_LEVEL      (ML),
    .SHOW_CYCLES    (SC),
    .GAP_CYCLES     (GC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_sw    (in_sw),
    .led      (led),
    .listen   (listen),
    .level    (level),
    .win      (win),
    .lose     (lose)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [3:0] oh(input int s);
    logic [3:0] r;
    case (s)
      0: r = 4'b0001;
      1: r = 4'b0010;
      2: r = 4'b0100;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while the DUT sits in its one-cycle symbol-append state.
  task automatic add_sym();
    pat.push_back(int'(m_lfsr[1:0]));
  endtask

  // Watch a full replay of the pattern, optionally with input noise.
  task automatic show_round(input bit noise);
    foreach (pat[i]) begin
      for (int k = 0; k < SC + GC; k++) begin
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        in_sw    = 4'($urandom);
        start    = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        tick();
        chk("show_led", led, (k < SC) ? oh(pat[i]) : 4'b0000);
        chk("show_listen", listen, 0);
        chk("show_level", level, pat.size());
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    tick();
    chk("listen_on", listen, 1);
    chk("listen_led", led, 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_lose", lose, 0);
    chk("start_win", win, 0);
    chk("start_level", level, 0);
    pat.delete();
    add_sym();
  endtask

  // fail_round 0 plays to a win; otherwise the last entry of that round is wrong.
  // wrong_kind: 0 = 4'b0011, 1 = random non-one-hot, 2 = wrong one-hot.
  task automatic play_game(input int fail_round, input int wrong_kind);
    logic [3:0] bad [12];
    bad = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    start_game();
    for (int r = 1; r <= ML; r++) begin
      show_round(1'b1);
      for (int i = 0; i < r; i++) begin
        in_valid = 1'b1;
        if (r == fail_round && i == r - 1) begin
          case (wrong_kind)
            0:       in_sw = 4'b0011;
            1:       in_sw = bad[$urandom_range(0, 11)];
            default: in_sw = oh((pat[i] + 1 + $urandom_range(0, 2)) % 4);
          endcase
          tick();
          in_valid = 1'b0;
          chk("lose_flag", lose, 1);
          chk("lose_listen", listen, 0);
          chk("lose_led", led, 0);
          chk("lose_win", win, 0);
          return;
        end
        in_sw = oh(pat[i]);
        tick();
        in_valid = 1'b0;
        if (i < r - 1) begin
          chk("match_listen", listen, 1);
          chk("match_lose", lose, 0);
        end else if (r < ML) begin
          chk("round_listen", listen, 0);
          chk("round_level", level, r);
          add_sym();
        end else begin
          chk("win_flag", win, 1);
          chk("win_led", led, 4'b1111);
          chk("win_listen", listen, 0);
          for (int k = 0; k < 55; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sw    = 4'($urandom);
            tick();
            chk("win_hold", {win, lose, led}, {1'b1, 1'b0, 4'b1111});
          end
          in_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_sw    = 4'b0000;
    repeat (3) tick();
    chk("rst_led", led, 0);
    chk("rst_listen", listen, 0);
    chk("rst_level", level, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    reset = 1'b0;

    // Entries in IDLE are ignored.
    in_valid = 1'b1;
    in_sw    = 4'b0001;
    tick();
    in_valid = 1'b0;
    chk("idle_listen", listen, 0);
    chk("idle_lose", lose, 0);

    play_game(1, 0);
    play_game(0, 0);
    play_game(2, 2);
    play_game(3, 1);
    play_game(2, 1);
    play_game(0, 0);

    // Reset in the middle of round two's replay.
    start_game();
    show_round(1'b0);
    in_valid = 1'b1;
    in_sw    = oh(pat[0]);
    tick();
    in_valid = 1'b0;
    chk("r2_listen", listen, 0);
    add_sym();
    repeat (3) tick();
    chk("r2_show_led", led, oh(pat[0]));
    chk("r2_level", level, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_all", {led, listen, level, win, lose}, 0);
    tick();
    chk("midrst_idle_level", level, 0);
    chk("midrst_idle_led", led, 0);

    // No player entry while listening.
    start_game();
    show_round(1'b0);
`ifdef SIMON_TIMEOUT_EN
    for (int k = 1; k <= TC; k++) begin
      tick();
      chk("timeout_lose", lose, (k == TC) ? 1 : 0);
    end
    chk("timeout_listen", listen, 0);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("no_timeout", {lose, listen}, 2'b01);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
